fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Program-counter sequencer for the single-cycle core. Owns the PC register, the run/halt state machine, and a runtime-writable 32-entry branch-target table that maps a 5-bit table index to a 10-bit absolute instruction address. Per-program targets are loaded through a configuration port instead of being fixed at synthesis, so one build runs every program. Sits between the instruction decoder, which supplies halt, branch and index signals, and the instruction ROM, which consumes the PC.

## Interface
- PC_W, 10, PC and target width; instruction space is 2**PC_W words
- IDX_W, 5, table index width; table depth is 2**IDX_W
- CNT_W, 16, taken-branch counter width
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high; clears all state
- Start  in  1  begin or restart the program; sampled in IDLE and HALT only
- Stall  in  1  freeze PC, state and counter this cycle
- Halt  in  1  decoder: current instruction is halt
- BranchEn  in  1  decoder: current instruction is a taken branch
- TableIdx  in  IDX_W  branch-target table index
- CfgWe  in  1  table write enable
- CfgAddr  in  IDX_W  table write index
- CfgData  in  PC_W  table write data
- PC  out  PC_W  registered program counter
- Running  out  1  high in RUN
- Done  out  1  registered; high in HALT
- BranchCount  out  CNT_W  saturating count of taken branches since last Start

## Operation
- States: IDLE, RUN, HALT, encoded as a 2-bit enum.
- Reset:
  - state=IDLE, PC=0, Done=0, Running=0, BranchCount=0.
  - All table entries are 0.
- IDLE:
  - PC holds 0.
  - Start=1 -> RUN, PC=0, BranchCount=0.
- RUN, evaluated in priority order:
  1. Stall=1 -> hold everything.
  2. Halt=1 -> HALT; PC holds.
  3. BranchEn=1 -> PC=table[TableIdx]; BranchCount+1, saturating at 2**CNT_W-1.
  4. Otherwise PC=PC+1, modulo 2**PC_W, so 1023 wraps to 0.
- Start in RUN is ignored.
- HALT:
  - PC, BranchCount and Done=1 hold.
  - Start=1 -> RUN, PC=0, BranchCount=0, Done=0. Stall does not block a restart.
- Halt and BranchEn together in RUN: Halt wins; the counter does not increment.
- Table configuration:
  - Writes are accepted in every state, including during Stall.
  - CfgWe=1 writes CfgData to entry CfgAddr at the clock edge.
  - Branch reads are combinational from the table. A write and a branch read to the same entry in the same cycle return the old value; there is no bypass.
- Reset mid-run forces IDLE immediately and clears the table; targets must be reloaded.

## Timing
- The PC update is visible one cycle after the edge that samples the control inputs.
- Branch latency: BranchEn sampled at edge n -> PC=target after edge n.
- Done rises the cycle after Halt is sampled in RUN. Running falls in the same cycle.
- Restart: Start sampled in HALT -> Running=1, Done=0 and PC=0 after that edge.
- A config write at edge n is visible to a branch sampled at edge n+1.
- No combinational path from any input to PC, Done, Running or BranchCount.

## Structure
- fetch_pkg:
  - state_t enum {IDLE, RUN, HALT}
  - default PC_W/IDX_W/CNT_W localparams
- Sub-module target_table:
  - 2**IDX_W x PC_W register array with async-reset clear
  - one write port and one combinational read port
- fetch_ctrl holds the FSM, the PC register, the counter and the next-PC mux.

## Test plan
- Reset, write table[3]=0x045, Start, run 3 cycles, BranchEn=1 with TableIdx=3 -> PC sequence 0,1,2,3 then 0x045; BranchCount=1.
- In RUN with PC=1023 and no branch -> PC=0 next cycle; Running stays 1.
- Stall=1 with BranchEn=1 for 2 cycles, then Stall=0 -> PC holds for 2 cycles, branch taken after release; BranchCount increments once.
- Halt=1 and BranchEn=1 together -> Done=1 next cycle, PC unchanged, BranchCount unchanged. Start -> PC=0, Done=0, BranchCount=0.
- Same cycle CfgWe=1, CfgAddr=5, CfgData=0x100, BranchEn=1, TableIdx=5 with old table[5]=0x010 -> PC=0x010. A branch one cycle later to index 5 -> PC=0x100.
- Assert Reset mid-RUN with PC=0x07B -> PC=0, IDLE and all entries 0 without waiting for a clock edge; later branches resolve to 0x000.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the fetch sequencer.
// Pure declarations; no logic, no latency.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam int PC_W_DEF  = 10;
   localparam int IDX_W_DEF = 5;
   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/target_table.sv
// Runtime-loaded branch-target table: one write port, one combinational read port.
// Write lands at the clock edge; read is zero-latency with no write bypass (old data returned).
module target_table #(
   parameter int PC_W  = 10,
   parameter int IDX_W = 5
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             CfgWe,
   input  logic [IDX_W-1:0] CfgAddr,
   input  logic [PC_W-1:0]  CfgData,
   input  logic [IDX_W-1:0] TableIdx,
   output logic [PC_W-1:0]  Target
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [PC_W-1:0] mem [DEPTH];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (CfgWe) begin
         mem[CfgAddr] <= CfgData;
      end
   end

   assign Target = mem[TableIdx];

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer: run/halt FSM, PC register, saturating taken-branch counter, next-PC mux.
// All outputs registered; control inputs take effect one edge after sampling; Stall freezes RUN.
module fetch_ctrl
   import fetch_pkg::*;
#(
   parameter int PC_W  = PC_W_DEF,
   parameter int IDX_W = IDX_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stall,
   input  logic             Halt,
   input  logic             BranchEn,
   input  logic [IDX_W-1:0] TableIdx,
   input  logic             CfgWe,
   input  logic [IDX_W-1:0] CfgAddr,
   input  logic [PC_W-1:0]  CfgData,
   output logic [PC_W-1:0]  PC,
   output logic             Running,
   output logic             Done,
   output logic [CNT_W-1:0] BranchCount
);

   state_t          state;
   logic [PC_W-1:0] target;

   target_table #(
      .PC_W  (PC_W),
      .IDX_W (IDX_W)
   ) u_table (
      .Clk      (Clk),
      .Reset    (Reset),
      .CfgWe    (CfgWe),
      .CfgAddr  (CfgAddr),
      .CfgData  (CfgData),
      .TableIdx (TableIdx),
      .Target   (target)
   );

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= IDLE;
         PC          <= '0;
         Running     <= 1'b0;
         Done        <= 1'b0;
         BranchCount <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  state       <= RUN;
                  PC          <= '0;
                  Running     <= 1'b1;
                  Done        <= 1'b0;
                  BranchCount <= '0;
               end
            end
            RUN: begin
               // Halt outranks BranchEn, so a halting branch neither jumps nor counts.
               if (!Stall) begin
                  if (Halt) begin
                     state   <= HALT;
                     Running <= 1'b0;
                     Done    <= 1'b1;
                  end else if (BranchEn) begin
                     PC <= target;
                     if (BranchCount != {CNT_W{1'b1}}) begin
                        BranchCount <= BranchCount + CNT_W'(1);
                     end
                  end else begin
                     PC <= PC + PC_W'(1);
                  end
               end
            end
            HALT: begin
               if (Start) begin
                  state       <= RUN;
                  PC          <= '0;
                  Running     <= 1'b1;
                  Done        <= 1'b0;
                  BranchCount <= '0;
               end
            end
            default: begin
               state   <= IDLE;
               PC      <= '0;
               Running <= 1'b0;
               Done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic        Stall;
   logic        Halt;
   logic        BranchEn;
   logic [4:0]  TableIdx;
   logic        CfgWe;
   logic [4:0]  CfgAddr;
   logic [9:0]  CfgData;
   logic [9:0]  PC;
   logic        Running;
   logic        Done;
   logic [15:0] BranchCount;

   int tests = 0;
   int fails = 0;

   fetch_ctrl dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .Stall       (Stall),
      .Halt        (Halt),
      .BranchEn    (BranchEn),
      .TableIdx    (TableIdx),
      .CfgWe       (CfgWe),
      .CfgAddr     (CfgAddr),
      .CfgData     (CfgData),
      .PC          (PC),
      .Running     (Running),
      .Done        (Done),
      .BranchCount (BranchCount)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [9:0] pc, input logic run,
                          input logic dn, input logic [15:0] cnt);
      chk({tag, ".pc"},   32'(PC),          32'(pc));
      chk({tag, ".run"},  32'(Running),     32'(run));
      chk({tag, ".done"}, 32'(Done),        32'(dn));
      chk({tag, ".cnt"},  32'(BranchCount), 32'(cnt));
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; Stall = 1'b0; Halt = 1'b0; BranchEn = 1'b0;
      TableIdx = '0; CfgWe = 1'b0; CfgAddr = '0; CfgData = '0;
      #2;
      chk_all("reset", 10'h000, 1'b0, 1'b0, 16'd0);
      tick(); tick();
      Reset = 1'b0;

      // Load table[3] while idle, then start and branch.
      CfgWe = 1'b1; CfgAddr = 5'd3; CfgData = 10'h045;
      tick();
      CfgWe = 1'b0;
      chk_all("idle", 10'h000, 1'b0, 1'b0, 16'd0);
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk_all("start", 10'h000, 1'b1, 1'b0, 16'd0);
      tick(); chk("seq1", 32'(PC), 32'h001);
      tick(); chk("seq2", 32'(PC), 32'h002);
      tick(); chk("seq3", 32'(PC), 32'h003);
      BranchEn = 1'b1; TableIdx = 5'd3;
      tick();
      BranchEn = 1'b0;
      chk_all("br3", 10'h045, 1'b1, 1'b0, 16'd1);

      // Config write during RUN, then branch to 1023 and wrap.
      CfgWe = 1'b1; CfgAddr = 5'd7; CfgData = 10'h3FF;
      tick();
      CfgWe = 1'b0;
      chk("cfg_run_pc", 32'(PC), 32'h046);
      BranchEn = 1'b1; TableIdx = 5'd7;
      tick();
      BranchEn = 1'b0;
      chk_all("br7", 10'h3FF, 1'b1, 1'b0, 16'd2);
      tick();
      chk_all("wrap", 10'h000, 1'b1, 1'b0, 16'd2);

      // Stall holds a pending branch for two cycles.
      Stall = 1'b1; BranchEn = 1'b1; TableIdx = 5'd3;
      tick(); chk_all("stall1", 10'h000, 1'b1, 1'b0, 16'd2);
      tick(); chk_all("stall2", 10'h000, 1'b1, 1'b0, 16'd2);
      Stall = 1'b0;
      tick();
      BranchEn = 1'b0;
      chk_all("stall_rel", 10'h045, 1'b1, 1'b0, 16'd3);

      // Config write accepted while stalled.
      Stall = 1'b1; CfgWe = 1'b1; CfgAddr = 5'd5; CfgData = 10'h010;
      tick();
      Stall = 1'b0; CfgWe = 1'b0;
      chk("stall_cfg_pc", 32'(PC), 32'h045);

      // Halt beats BranchEn.
      Halt = 1'b1; BranchEn = 1'b1; TableIdx = 5'd7;
      tick();
      Halt = 1'b0; BranchEn = 1'b0;
      chk_all("halt", 10'h045, 1'b0, 1'b1, 16'd3);
      tick();
      chk_all("halt_hold", 10'h045, 1'b0, 1'b1, 16'd3);
      Start = 1'b1; Stall = 1'b1;
      tick();
      Start = 1'b0; Stall = 1'b0;
      chk_all("restart", 10'h000, 1'b1, 1'b0, 16'd0);

      // Write and branch to the same entry in one cycle: old target used.
      CfgWe = 1'b1; CfgAddr = 5'd5; CfgData = 10'h100; BranchEn = 1'b1; TableIdx = 5'd5;
      tick();
      CfgWe = 1'b0;
      chk_all("wr_rd_same", 10'h010, 1'b1, 1'b0, 16'd1);
      tick();
      BranchEn = 1'b0;
      chk_all("wr_visible", 10'h100, 1'b1, 1'b0, 16'd2);

      // Start in RUN ignored.
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk_all("start_in_run", 10'h101, 1'b1, 1'b0, 16'd2);

      // Reach PC=0x07B, then reset asynchronously mid-cycle.
      CfgWe = 1'b1; CfgAddr = 5'd9; CfgData = 10'h07B;
      tick();
      CfgWe = 1'b0;
      BranchEn = 1'b1; TableIdx = 5'd9;
      tick();
      BranchEn = 1'b0;
      chk("pc_7b", 32'(PC), 32'h07B);
      #2;
      Reset = 1'b1;
      #1;
      chk_all("async_rst", 10'h000, 1'b0, 1'b0, 16'd0);
      tick();
      Reset = 1'b0;
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk_all("post_rst_start", 10'h000, 1'b1, 1'b0, 16'd0);
      BranchEn = 1'b1; TableIdx = 5'd3;
      tick(); chk_all("cleared3", 10'h000, 1'b1, 1'b0, 16'd1);
      TableIdx = 5'd9;
      tick(); chk_all("cleared9", 10'h000, 1'b1, 1'b0, 16'd2);
      TableIdx = 5'd7;
      tick(); chk_all("cleared7", 10'h000, 1'b1, 1'b0, 16'd3);
      BranchEn = 1'b0;
      tick(); chk("post_clear_inc", 32'(PC), 32'h001);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
